// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce/edge-detect block.
package debounce_pkg;

  localparam int unsigned STABLE_CYCLES_DEF = 4;
  localparam int unsigned TIMER_WIDTH_DEF   = 4;
  localparam int unsigned EVT_WIDTH_DEF     = 8;

  // Debounce FSM: two stable levels, each with a check state toward the other
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } db_state_e;

endpackage

// File: rtl/debounce_edge_if.sv
// Signal bundle between the synchronized input source and the debouncer.
interface debounce_edge_if
  import debounce_pkg::*;
#(
  parameter int unsigned EVT_WIDTH = EVT_WIDTH_DEF
);

  logic                 sync_in;
  logic                 clear;
  logic                 level;
  logic                 rise_pulse;
  logic                 fall_pulse;
  logic [EVT_WIDTH-1:0] edge_count;

  modport master (
    output sync_in,
    output clear,
    input  level,
    input  rise_pulse,
    input  fall_pulse,
    input  edge_count
  );

  modport slave (
    input  sync_in,
    input  clear,
    output level,
    output rise_pulse,
    output fall_pulse,
    output edge_count
  );

endinterface

// File: rtl/flex_counter.sv
// Stability timer: counts enabled cycles, flags when the count reaches rollover_val.
module flex_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;

  // Increment, wrapping to zero once the rollover value has been reached
  always_comb begin
    count_next = count + WIDTH'(1);
    if (count == rollover_val) begin
      count_next = '0;
    end
  end

  // Count register; the flag tracks whether the held count equals rollover_val
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count         <= '0;
      rollover_flag <= 1'b0;
    end else if (clear) begin
      count         <= '0;
      rollover_flag <= (rollover_val == '0);
    end else if (count_enable) begin
      count         <= count_next;
      rollover_flag <= (count_next == rollover_val);
    end
  end

endmodule

// File: rtl/debounce_edge.sv
// Debouncer with registered level, rise/fall pulses and an optional saturating
// edge counter (built only when DEBOUNCE_EDGE_EVT_COUNT_EN is defined).
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned TIMER_WIDTH   = TIMER_WIDTH_DEF,
  parameter int unsigned EVT_WIDTH     = EVT_WIDTH_DEF
) (
  input logic             clk,
  input logic             n_rst,
  debounce_edge_if.slave  bus
);

  localparam logic [TIMER_WIDTH-1:0] ROLLOVER = TIMER_WIDTH'(STABLE_CYCLES - 1);
  localparam bit SINGLE_CYCLE = (STABLE_CYCLES == 1);

  db_state_e state;
  db_state_e state_next;
  logic      level_q;
  logic      level_next;
  logic      rise_q;
  logic      rise_next;
  logic      fall_q;
  logic      fall_next;
  logic      edge_next;
  logic      timer_clear;
  logic      timer_en;
  logic      timer_done;

  flex_counter #(
    .WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (timer_clear),
    .count_enable  (timer_en),
    .rollover_val  (ROLLOVER),
    .rollover_flag (timer_done)
  );

  // State, level and pulse registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= STABLE_LO;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state   <= state_next;
      level_q <= level_next;
      rise_q  <= rise_next;
      fall_q  <= fall_next;
    end
  end

  // Next-state, timer control and next level/pulse values
  always_comb begin
    state_next  = state;
    level_next  = level_q;
    rise_next   = 1'b0;
    fall_next   = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    unique case (state)
      STABLE_LO: begin
        if (bus.sync_in) begin
          if (SINGLE_CYCLE) begin
            state_next = STABLE_HI;
            level_next = 1'b1;
            rise_next  = 1'b1;
          end else begin
            state_next = CHECK_HI;
            timer_en   = 1'b1;
          end
        end
      end
      CHECK_HI: begin
        if (!bus.sync_in) begin
          state_next  = STABLE_LO;
          timer_clear = 1'b1;
        end else if (timer_done) begin
          state_next  = STABLE_HI;
          timer_clear = 1'b1;
          level_next  = 1'b1;
          rise_next   = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end
      STABLE_HI: begin
        if (!bus.sync_in) begin
          if (SINGLE_CYCLE) begin
            state_next = STABLE_LO;
            level_next = 1'b0;
            fall_next  = 1'b1;
          end else begin
            state_next = CHECK_LO;
            timer_en   = 1'b1;
          end
        end
      end
      CHECK_LO: begin
        if (bus.sync_in) begin
          state_next  = STABLE_HI;
          timer_clear = 1'b1;
        end else if (timer_done) begin
          state_next  = STABLE_LO;
          timer_clear = 1'b1;
          level_next  = 1'b0;
          fall_next   = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: begin
        state_next  = STABLE_LO;
        timer_clear = 1'b1;
        level_next  = 1'b0;
      end
    endcase
    edge_next = rise_next | fall_next;
  end

  assign bus.level      = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;

`ifdef DEBOUNCE_EDGE_EVT_COUNT_EN
  logic [EVT_WIDTH-1:0] edge_count_q;

  // Saturating accepted-edge counter; clear wins, then the coincident edge counts
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      edge_count_q <= '0;
    end else if (bus.clear) begin
      edge_count_q <= edge_next ? EVT_WIDTH'(1) : '0;
    end else if (edge_next && (edge_count_q != '1)) begin
      edge_count_q <= edge_count_q + EVT_WIDTH'(1);
    end
  end

  assign bus.edge_count = edge_count_q;
`else
  logic unused_c;

  assign bus.edge_count = '0;
  assign unused_c       = bus.clear | edge_next;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge: main instance STABLE_CYCLES=4/EVT_WIDTH=2,
// second instance STABLE_CYCLES=1.
module tb_debounce_edge;

  localparam int unsigned EW      = 2;
  localparam int          CNT_MAX = (1 << EW) - 1;
`ifdef DEBOUNCE_EDGE_EVT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  int   exp_cnt1 = 0;

  always #5 clk = ~clk;

  debounce_edge_if #(.EVT_WIDTH(EW)) bus  ();
  debounce_edge_if #(.EVT_WIDTH(EW)) bus1 ();

  debounce_edge #(
    .STABLE_CYCLES (4),
    .TIMER_WIDTH   (4),
    .EVT_WIDTH     (EW)
  ) u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  debounce_edge #(
    .STABLE_CYCLES (1),
    .TIMER_WIDTH   (4),
    .EVT_WIDTH     (EW)
  ) u_dut1 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus1)
  );

  // Observed {level, rise, fall, edge_count}
  function automatic logic [EW+2:0] obs();
    return {bus.level, bus.rise_pulse, bus.fall_pulse, bus.edge_count};
  endfunction

  function automatic logic [EW+2:0] obs1();
    return {bus1.level, bus1.rise_pulse, bus1.fall_pulse, bus1.edge_count};
  endfunction

  function automatic logic [EW-1:0] cnt_of(input int n);
    return CNT_EN ? EW'(n) : '0;
  endfunction

  function automatic int sat_inc(input int n);
    return (n < CNT_MAX) ? n + 1 : CNT_MAX;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [EW+2:0] want;
    n_rst = 1'b0;
    bus.sync_in = 1'b0;  bus.clear = 1'b0;
    bus1.sync_in = 1'b0; bus1.clear = 1'b0;
    #12;
    want = '0;
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL reset_in_reset got %b want %b", obs(), want);
    end
    @(negedge clk);
    n_rst = 1'b1;
    exp_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (obs() !== want) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got %b want %b", k, obs(), want);
      end
    end
  endtask

  task automatic test_rise();
    logic [EW+2:0] want;
    bus.sync_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 4) exp_cnt = sat_inc(exp_cnt);
      want = {(k >= 4), (k == 4), 1'b0, cnt_of(exp_cnt)};
      checks++;
      if (obs() !== want) begin
        errors++;
        $display("FAIL rise cyc %0d got %b want %b", k, obs(), want);
      end
    end
  endtask

  task automatic test_glitch();
    logic [EW+2:0] want;
    bus.sync_in = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 4) exp_cnt = sat_inc(exp_cnt);
      want = {(k < 4), 1'b0, (k == 4), cnt_of(exp_cnt)};
      checks++;
      if (obs() !== want) begin
        errors++;
        $display("FAIL fall cyc %0d got %b want %b", k, obs(), want);
      end
    end
    for (int k = 0; k < 9; k++) begin
      bus.sync_in = (k < 3);
      tick();
      want = {1'b0, 1'b0, 1'b0, cnt_of(exp_cnt)};
      checks++;
      if (obs() !== want) begin
        errors++;
        $display("FAIL glitch cyc %0d got %b want %b", k, obs(), want);
      end
    end
    bus.sync_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) exp_cnt = sat_inc(exp_cnt);
      want = {(k == 4), (k == 4), 1'b0, cnt_of(exp_cnt)};
      checks++;
      if (obs() !== want) begin
        errors++;
        $display("FAIL post_glitch_rise cyc %0d got %b want %b", k, obs(), want);
      end
    end
  endtask

  task automatic test_saturate_clear();
    logic [EW+2:0] want;
    logic          newv;
    for (int e = 0; e < 2; e++) begin
      newv = (e == 1);
      bus.sync_in = newv;
      for (int k = 1; k <= 4; k++) begin
        tick();
        if (k == 4) exp_cnt = sat_inc(exp_cnt);
        want = {((k == 4) ? newv : !newv), (k == 4) && newv, (k == 4) && !newv,
                cnt_of(exp_cnt)};
        checks++;
        if (obs() !== want) begin
          errors++;
          $display("FAIL saturate edge %0d cyc %0d got %b want %b", e, k, obs(), want);
        end
      end
    end
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    exp_cnt = 0;
    want = {1'b1, 1'b0, 1'b0, cnt_of(exp_cnt)};
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL clear_alone got %b want %b", obs(), want);
    end
    bus.sync_in = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      want = {1'b1, 1'b0, 1'b0, cnt_of(exp_cnt)};
      checks++;
      if (obs() !== want) begin
        errors++;
        $display("FAIL clear_pre_edge cyc %0d got %b want %b", k, obs(), want);
      end
    end
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    exp_cnt = 1;
    want = {1'b0, 1'b0, 1'b1, cnt_of(exp_cnt)};
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL clear_with_edge got %b want %b", obs(), want);
    end
  endtask

  task automatic test_reset_mid_check();
    logic [EW+2:0] want;
    bus.sync_in = 1'b1;
    tick();
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    exp_cnt = 0;
    exp_cnt1 = 0;
    want = '0;
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL reset_mid_async got %b want %b", obs(), want);
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 4) exp_cnt = sat_inc(exp_cnt);
      want = {(k >= 4), (k == 4), 1'b0, cnt_of(exp_cnt)};
      checks++;
      if (obs() !== want) begin
        errors++;
        $display("FAIL reset_mid_rise cyc %0d got %b want %b", k, obs(), want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [EW+2:0] want;
    logic          newv;
    for (int e = 0; e < 6; e++) begin
      newv = (e % 2 == 1);
      bus.sync_in = newv;
      for (int k = 1; k <= 4; k++) begin
        tick();
        if (k == 4) exp_cnt = sat_inc(exp_cnt);
        want = {((k == 4) ? newv : !newv), (k == 4) && newv, (k == 4) && !newv,
                cnt_of(exp_cnt)};
        checks++;
        if (obs() !== want) begin
          errors++;
          $display("FAIL back_to_back edge %0d cyc %0d got %b want %b", e, k, obs(), want);
        end
      end
    end
  endtask

  task automatic test_single_cycle();
    logic [EW+2:0] want;
    logic          newv;
    for (int e = 0; e < 4; e++) begin
      newv = (e % 2 == 0);
      bus1.sync_in = newv;
      tick();
      exp_cnt1 = sat_inc(exp_cnt1);
      want = {newv, newv, !newv, cnt_of(exp_cnt1)};
      checks++;
      if (obs1() !== want) begin
        errors++;
        $display("FAIL single_edge %0d got %b want %b", e, obs1(), want);
      end
      tick();
      want = {newv, 1'b0, 1'b0, cnt_of(exp_cnt1)};
      checks++;
      if (obs1() !== want) begin
        errors++;
        $display("FAIL single_hold %0d got %b want %b", e, obs1(), want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_saturate_clear();
    test_reset_mid_check();
    test_back_to_back();
    test_single_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_edge.md
DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive differing samples needed to accept a level change (legal 1..2^TIMER_WIDTH-1).
REQ-002 SHALL have parameter TIMER_WIDTH, default 4, meaning the stability timer width.
REQ-003 SHALL have parameter EVT_WIDTH, default 8, meaning the edge event counter width.
REQ-004 SHALL have clk  input  1  system clock, rising-edge active.
REQ-005 SHALL have n_rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have sync_in  input  1  already-synchronized input level from the upstream two-flop synchronizer.
REQ-007 SHALL have clear  input  1  synchronous clear of the event counter.
REQ-008 SHALL have level  output  1  debounced level.
REQ-009 SHALL have rise_pulse  output  1  one-cycle pulse on an accepted 0->1 change.
REQ-010 SHALL have fall_pulse  output  1  one-cycle pulse on an accepted 1->0 change.
REQ-011 SHALL have edge_count  output  EVT_WIDTH  count of accepted edges, saturating.

Function
REQ-012 SHALL implement a four-state FSM: STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO.
REQ-013 STABLE_LO: sync_in=1 -> CHECK_HI with timer=1; otherwise stay. STABLE_HI mirrors this with sync_in=0 -> CHECK_LO.
REQ-014 CHECK_HI: sync_in=0 -> STABLE_LO with timer=0 (glitch rejected, no pulse). With sync_in=1 and timer=STABLE_CYCLES-1 -> STABLE_HI. Otherwise timer increments. CHECK_LO mirrors this.
REQ-015 For STABLE_CYCLES=1, the transition from STABLE_x SHALL skip CHECK_x and go directly to the opposite stable state on the first differing sample.
REQ-016 level SHALL be registered. It changes on the clock edge that completes STABLE_CYCLES consecutive differing samples, i.e. STABLE_CYCLES cycles after sync_in first differs.
REQ-017 rise_pulse/fall_pulse SHALL be registered and asserted in exactly the cycle level first shows the new value; never both high.
REQ-018 edge_count SHALL increment by 1 on each accepted edge and hold at all-ones (no wrap).
REQ-019 When clear and an accepted edge coincide, edge_count SHALL become 1 (clear then count).
REQ-020 clear SHALL not affect the FSM, level, or pulses.
REQ-021 The timer SHALL never exceed STABLE_CYCLES-1 and SHALL be 0 in both stable states.

Reset
REQ-022 On n_rst low, asynchronously: state=STABLE_LO, timer=0, level=0, rise_pulse=0, fall_pulse=0, edge_count=0.
REQ-023 If reset is asserted mid-CHECK, the pending change SHALL be discarded. After release, a held-high input produces a rise STABLE_CYCLES cycles later.

Configuration
REQ-024 Macro DEBOUNCE_EDGE_EVT_COUNT_EN: when defined, edge_count logic SHALL be built per REQ-018/019.
REQ-025 When the macro is undefined, edge_count SHALL be tied to 0, clear SHALL be ignored, and no counter flops SHALL be inferred.

Structure
REQ-026 The FSM state enum type and the default STABLE_CYCLES/TIMER_WIDTH constants SHALL live in shared package debounce_pkg.
REQ-027 The stability timer SHALL be one instantiated sub-module, flex_counter (clear, count_enable, rollover value = STABLE_CYCLES-1, rollover flag).

Verification
REQ-028 Reset, sync_in=0 for 10 cycles -> level=0, no pulses, edge_count=0.
REQ-029 STABLE_CYCLES=4: sync_in 0->1 at cycle 0 and held -> level=1 and rise_pulse=1 at cycle 4 only; edge_count=1.
REQ-030 sync_in high for 3 cycles, then low -> no level change, no pulse, FSM returns to STABLE_LO.
REQ-031 EVT_WIDTH=2, five accepted edges -> edge_count=3 (saturated). Then clear -> 0; clear coincident with an edge -> 1.
REQ-032 n_rst pulsed during CHECK_HI at timer=2 -> all outputs 0 immediately. With sync_in held high, rise at the 4th edge after release.
REQ-033 Macro undefined: toggling pattern with 6 accepted edges -> edge_count stays 0, and pulses are identical to the macro-defined run.
